// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue/collect controller and its decoder.
package alu_pkg;

   // ALU operation codes as seen on the alu_op port
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_NOR = 4'b1100,
      ALU_SLL = 4'b1000
   } alu_op_e;

   // ALU flag select: zero test or sign of result
   typedef enum logic [2:0] {
      FLAG_ZERO = 3'b000,
      FLAG_SIGN = 3'b100
   } flag_sel_e;

   // RV64 major opcodes handled by this controller
   typedef enum logic [6:0] {
      OPC_R      = 7'b0110011,
      OPC_I      = 7'b0010011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_BRANCH = 7'b1100011
   } opcode_e;

   // funct3 values for the supported arithmetic/logic group
   typedef enum logic [2:0] {
      F3_ADD_SUB = 3'b000,
      F3_SLL     = 3'b001,
      F3_OR      = 3'b110,
      F3_AND     = 3'b111
   } arith_f3_e;

   // funct3 values for the supported branches
   typedef enum logic [2:0] {
      F3_BEQ = 3'b000,
      F3_BLT = 3'b100
   } branch_f3_e;

   typedef struct packed {
      alu_op_e op;
      logic    is_shift;
      logic    legal;
   } arith_dec_t;

   // Map an R/I funct3 to an ALU op; sub selects SUB for funct3 000
   function automatic arith_dec_t decode_arith(input logic [2:0] f3, input logic sub);
      arith_dec_t d;
      d = '{op: ALU_AND, is_shift: 1'b0, legal: 1'b1};
      case (f3)
         F3_ADD_SUB: d.op = sub ? ALU_SUB : ALU_ADD;
         F3_AND:     d.op = ALU_AND;
         F3_OR:      d.op = ALU_OR;
         F3_SLL: begin
            d.op       = ALU_SLL;
            d.is_shift = 1'b1;
         end
         default:    d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of RV64 instruction fields into ALU controls and operands.
module alu_ctrl_decode
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic [WIDTH-1:0] rs1_data,
   input  logic [WIDTH-1:0] rs2_data,
   input  logic [WIDTH-1:0] imm,
   output logic [3:0]       alu_op,
   output logic [2:0]       alu_funct3,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             is_branch,
   output logic             illegal
);

   arith_dec_t r_dec;
   arith_dec_t i_dec;
   logic [WIDTH-1:0] rs2_shamt;
   logic [WIDTH-1:0] imm_shamt;

   // Per-format arithmetic decode and zero-extended shift amounts
   always_comb begin
      r_dec     = decode_arith(funct3, funct7_5);
      i_dec     = decode_arith(funct3, 1'b0);
      rs2_shamt = {{(WIDTH-6){1'b0}}, rs2_data[5:0]};
      imm_shamt = {{(WIDTH-6){1'b0}}, imm[5:0]};
   end

   // Select op, flag select and second operand from the opcode class
   always_comb begin
      alu_op     = ALU_AND;
      alu_funct3 = FLAG_ZERO;
      a          = rs1_data;
      b          = '0;
      is_branch  = 1'b0;
      illegal    = 1'b0;
      case (opcode)
         OPC_R: begin
            if (r_dec.legal) begin
               alu_op = r_dec.op;
               b      = r_dec.is_shift ? rs2_shamt : rs2_data;
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_I: begin
            if (i_dec.legal) begin
               alu_op = i_dec.op;
               b      = i_dec.is_shift ? imm_shamt : imm;
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_LOAD, OPC_STORE: begin
            alu_op = ALU_ADD;
            b      = imm;
         end
         OPC_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BLT) begin
               alu_op     = ALU_SUB;
               alu_funct3 = funct3;
               b          = rs2_data;
               is_branch  = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/collect controller in front of a combinational 64-bit ALU.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic [WIDTH-1:0] rs1_data,
   input  logic [WIDTH-1:0] rs2_data,
   input  logic [WIDTH-1:0] imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   output logic [2:0]       alu_funct3,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_is_branch,
   output logic             out_taken,
   output logic             out_illegal
);

   logic [3:0]       dec_op;
   logic [2:0]       dec_f3;
   logic [WIDTH-1:0] dec_a;
   logic [WIDTH-1:0] dec_b;
   logic             dec_br;
   logic             dec_ill;

   logic             w_adv, e_adv, accept, w_load;

   logic             e_valid_q, e_valid_d;
   logic [3:0]       e_op_q, e_op_d;
   logic [2:0]       e_f3_q, e_f3_d;
   logic [WIDTH-1:0] e_a_q, e_a_d;
   logic [WIDTH-1:0] e_b_q, e_b_d;
   logic             e_br_q, e_br_d;
   logic             e_ill_q, e_ill_d;

   logic             w_valid_q, w_valid_d;
   logic [WIDTH-1:0] w_result_q, w_result_d;
   logic             w_br_q, w_br_d;
   logic             w_taken_q, w_taken_d;
   logic             w_ill_q, w_ill_d;

   alu_ctrl_decode #(.WIDTH(WIDTH)) u_decode (
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7_5   (funct7_5),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .imm        (imm),
      .alu_op     (dec_op),
      .alu_funct3 (dec_f3),
      .a          (dec_a),
      .b          (dec_b),
      .is_branch  (dec_br),
      .illegal    (dec_ill)
   );

   // Stage advance: each stage moves when empty or when the stage after it moves
   always_comb begin
      w_adv  = !w_valid_q | out_ready;
      e_adv  = !e_valid_q | w_adv;
      accept = in_valid & e_adv;
      w_load = e_valid_q & w_adv;
   end

   // Next-state for E (loaded on accept) and W (loaded when E drains)
   always_comb begin
      e_valid_d  = e_adv ? in_valid : e_valid_q;
      e_op_d     = accept ? dec_op  : e_op_q;
      e_f3_d     = accept ? dec_f3  : e_f3_q;
      e_a_d      = accept ? dec_a   : e_a_q;
      e_b_d      = accept ? dec_b   : e_b_q;
      e_br_d     = accept ? dec_br  : e_br_q;
      e_ill_d    = accept ? dec_ill : e_ill_q;

      w_valid_d  = w_adv ? e_valid_q : w_valid_q;
      w_result_d = w_result_q;
      w_br_d     = w_br_q;
      w_taken_d  = w_taken_q;
      w_ill_d    = w_ill_q;
      if (w_load) begin
         w_result_d = e_ill_q ? '0 : alu_result;
         w_br_d     = e_br_q;
         w_taken_d  = e_br_q & alu_zero;
         w_ill_d    = e_ill_q;
      end
   end

   // Pipeline registers; reset empties both stages and clears all data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_valid_q  <= 1'b0;
         e_op_q     <= '0;
         e_f3_q     <= '0;
         e_a_q      <= '0;
         e_b_q      <= '0;
         e_br_q     <= 1'b0;
         e_ill_q    <= 1'b0;
         w_valid_q  <= 1'b0;
         w_result_q <= '0;
         w_br_q     <= 1'b0;
         w_taken_q  <= 1'b0;
         w_ill_q    <= 1'b0;
      end else begin
         e_valid_q  <= e_valid_d;
         e_op_q     <= e_op_d;
         e_f3_q     <= e_f3_d;
         e_a_q      <= e_a_d;
         e_b_q      <= e_b_d;
         e_br_q     <= e_br_d;
         e_ill_q    <= e_ill_d;
         w_valid_q  <= w_valid_d;
         w_result_q <= w_result_d;
         w_br_q     <= w_br_d;
         w_taken_q  <= w_taken_d;
         w_ill_q    <= w_ill_d;
      end
   end

   // Outputs come straight from the stage registers
   always_comb begin
      in_ready      = e_adv;
      alu_op        = e_op_q;
      alu_funct3    = e_f3_q;
      alu_a         = e_a_q;
      alu_b         = e_b_q;
      out_valid     = w_valid_q;
      out_result    = w_result_q;
      out_is_branch = w_br_q;
      out_taken     = w_taken_q;
      out_illegal   = w_ill_q;
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU beside the DUT, directed vector table,
// handshake corner sequences and a randomized scoreboard run.
module tb_alu_issue_ctrl;

   localparam int W = 64;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          funct7_5;
   logic [W-1:0]  rs1_data, rs2_data, imm;
   logic [W-1:0]  alu_a, alu_b;
   logic [3:0]    alu_op;
   logic [2:0]    alu_funct3;
   logic [W-1:0]  alu_result;
   logic          alu_zero;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic          out_is_branch;
   logic          out_taken;
   logic          out_illegal;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc   = 0;
   bit            last_acc = 1'b0;

   alu_issue_ctrl #(.WIDTH(W)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7_5      (funct7_5),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .imm           (imm),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_op        (alu_op),
      .alu_funct3    (alu_funct3),
      .alu_result    (alu_result),
      .alu_zero      (alu_zero),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_is_branch (out_is_branch),
      .out_taken     (out_taken),
      .out_illegal   (out_illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // The ALU that sits beside the controller
   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         4'b1100: alu_result = ~(alu_a | alu_b);
         4'b1000: alu_result = alu_a << alu_b[5:0];
         default: alu_result = '0;
      endcase
      alu_zero = (alu_funct3 == 3'b100) ? alu_result[W-1] : (alu_result == '0);
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected writeback for one instruction, from the instruction semantics
   typedef struct packed {
      logic [W-1:0] result;
      logic         br;
      logic         taken;
      logic         ill;
   } exp_t;

   function automatic exp_t ref_model(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic f75, input logic [W-1:0] r1,
                                      input logic [W-1:0] r2, input logic [W-1:0] im);
      exp_t e;
      logic [W-1:0] src;
      logic [W-1:0] diff;
      e = '0;
      diff = r1 - r2;
      src = (opc == 7'b0110011) ? r2 : im;
      if (opc == 7'b0110011 || opc == 7'b0010011) begin
         if (f3 == 3'b000)      e.result = (opc == 7'b0110011 && f75) ? r1 - src : r1 + src;
         else if (f3 == 3'b111) e.result = r1 & src;
         else if (f3 == 3'b110) e.result = r1 | src;
         else if (f3 == 3'b001) e.result = r1 << src[5:0];
         else                   e.ill = 1'b1;
      end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
         e.result = r1 + im;
      end else if (opc == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b100)) begin
         e.result = diff;
         e.br     = 1'b1;
         e.taken  = (f3 == 3'b000) ? (diff == '0) : diff[W-1];
      end else begin
         e.ill = 1'b1;
      end
      if (e.ill) e.result = '0;
      return e;
   endfunction

   exp_t exp_q[$];

   // Scoreboard: record accepts, check every output handshake in order
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         exp_q.delete();
         last_acc = 1'b0;
      end else begin
         last_acc = in_valid && in_ready;
         if (in_valid && in_ready)
            exp_q.push_back(ref_model(opcode, funct3, funct7_5, rs1_data, rs2_data, imm));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_output", 64'(exp_q.size()), 1);
            end else begin
               e = exp_q.pop_front();
               chk("sb_result", out_result, e.result);
               chk("sb_is_branch", 64'(out_is_branch), 64'(e.br));
               chk("sb_taken", 64'(out_taken), 64'(e.taken));
               chk("sb_illegal", 64'(out_illegal), 64'(e.ill));
            end
         end
      end
   end

   // Offer one instruction and hold it until accepted (bounded)
   task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                       input logic [W-1:0] r1, input logic [W-1:0] r2,
                       input logic [W-1:0] im, output bit ok);
      opcode = opc; funct3 = f3; funct7_5 = f75;
      rs1_data = r1; rs2_data = r2; imm = im;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int unsigned c = 0; c < 50; c++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         in_valid = 1'b0;
         chk("send_timeout", 64'(ok), 1);
      end
   endtask

   typedef struct {
      logic [6:0]   opc;
      logic [2:0]   f3;
      logic         f75;
      logic [W-1:0] rs1, rs2, im;
      logic [3:0]   e_op;
      logic [W-1:0] e_b;
      logic [2:0]   e_f3;
      logic [W-1:0] e_res;
      logic         e_br, e_tk, e_ill;
   } vec_t;

   vec_t vt[15];

   initial begin
      bit ok;
      bit ok3;
      int first_cyc, last_cyc, got;
      logic [W-1:0] bp_exp[4];

      vt[0]  = '{7'b0110011, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0,
                 4'b0010, 64'd7, 3'b000, 64'd12, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{7'b0110011, 3'b000, 1'b1, 64'd3, 64'd5, 64'd0,
                 4'b0110, 64'd5, 3'b000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{7'b0010011, 3'b001, 1'b0, 64'd1, 64'd0, 64'h43,
                 4'b1000, 64'd3, 3'b000, 64'd8, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{7'b1100011, 3'b000, 1'b0, 64'h10, 64'h10, 64'd0,
                 4'b0110, 64'h10, 3'b000, 64'd0, 1'b1, 1'b1, 1'b0};
      vt[4]  = '{7'b1100011, 3'b100, 1'b0, 64'd2, 64'd9, 64'd0,
                 4'b0110, 64'd9, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b1, 1'b0};
      vt[5]  = '{7'b1100011, 3'b100, 1'b0, 64'd9, 64'd2, 64'd0,
                 4'b0110, 64'd2, 3'b100, 64'd7, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{7'b0110111, 3'b000, 1'b0, 64'h55, 64'd3, 64'd4,
                 4'b0000, 64'd0, 3'b000, 64'd0, 1'b0, 1'b0, 1'b1};
      vt[7]  = '{7'b0110011, 3'b111, 1'b0, 64'hF0F0, 64'hFF00, 64'd0,
                 4'b0000, 64'hFF00, 3'b000, 64'hF000, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{7'b0010011, 3'b110, 1'b0, 64'h0F, 64'd0, 64'hF0,
                 4'b0001, 64'hF0, 3'b000, 64'hFF, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{7'b0000011, 3'b011, 1'b0, 64'h1000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8,
                 4'b0010, 64'hFFFF_FFFF_FFFF_FFF8, 3'b000, 64'hFF8, 1'b0, 1'b0, 1'b0};
      vt[10] = '{7'b0100011, 3'b010, 1'b0, 64'h20, 64'd0, 64'd4,
                 4'b0010, 64'd4, 3'b000, 64'h24, 1'b0, 1'b0, 1'b0};
      vt[11] = '{7'b0010011, 3'b000, 1'b1, 64'd10, 64'd99, 64'd3,
                 4'b0010, 64'd3, 3'b000, 64'd13, 1'b0, 1'b0, 1'b0};
      vt[12] = '{7'b0110011, 3'b010, 1'b0, 64'd5, 64'd6, 64'd0,
                 4'b0000, 64'd0, 3'b000, 64'd0, 1'b0, 1'b0, 1'b1};
      vt[13] = '{7'b1100011, 3'b001, 1'b0, 64'd4, 64'd4, 64'd0,
                 4'b0000, 64'd0, 3'b000, 64'd0, 1'b0, 1'b0, 1'b1};
      vt[14] = '{7'b0110011, 3'b001, 1'b1, 64'd3, 64'h41, 64'd0,
                 4'b1000, 64'd1, 3'b000, 64'd6, 1'b0, 1'b0, 1'b0};

      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; funct3 = '0; funct7_5 = 1'b0;
      rs1_data = '0; rs2_data = '0; imm = '0;

      // Reset state
      #12;
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_alu_op", 64'(alu_op), 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_funct3", 64'(alu_funct3), 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_flags", 64'({out_is_branch, out_taken, out_illegal}), 0);
      #5 reset = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, one at a time through an empty pipe
      for (int unsigned i = 0; i < 15; i++) begin
         send(vt[i].opc, vt[i].f3, vt[i].f75, vt[i].rs1, vt[i].rs2, vt[i].im, ok);
         chk($sformatf("v%0d_alu_op", i), 64'(alu_op), 64'(vt[i].e_op));
         chk($sformatf("v%0d_alu_a", i), alu_a, vt[i].rs1);
         chk($sformatf("v%0d_alu_b", i), alu_b, vt[i].e_b);
         chk($sformatf("v%0d_alu_funct3", i), 64'(alu_funct3), 64'(vt[i].e_f3));
         chk($sformatf("v%0d_early_out_valid", i), 64'(out_valid), 0);
         @(posedge clk); #1;
         chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 1);
         chk($sformatf("v%0d_out_result", i), out_result, vt[i].e_res);
         chk($sformatf("v%0d_out_is_branch", i), 64'(out_is_branch), 64'(vt[i].e_br));
         chk($sformatf("v%0d_out_taken", i), 64'(out_taken), 64'(vt[i].e_tk));
         chk($sformatf("v%0d_out_illegal", i), 64'(out_illegal), 64'(vt[i].e_ill));
         @(posedge clk); #1;
      end

      // Backpressure: two accepts fill E and W, then input stalls
      out_ready = 1'b0;
      for (int unsigned k = 0; k < 4; k++) bp_exp[k] = 64'(101 * (k + 1));
      send(7'b0110011, 3'b000, 1'b0, 64'd100, 64'd1, 64'd0, ok);
      send(7'b0110011, 3'b000, 1'b0, 64'd200, 64'd2, 64'd0, ok);
      chk("bp_in_ready_low", 64'(in_ready), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_in_ready_held", 64'(in_ready), 0);
      chk("bp_out_valid", 64'(out_valid), 1);
      chk("bp_out_result_held", out_result, 64'd101);
      chk("bp_alu_a_held", alu_a, 64'd200);
      chk("bp_alu_op_held", 64'(alu_op), 64'b0010);
      fork
         begin
            send(7'b0110011, 3'b000, 1'b0, 64'd300, 64'd3, 64'd0, ok3);
            send(7'b0110011, 3'b000, 1'b0, 64'd400, 64'd4, 64'd0, ok3);
         end
      join_none
      out_ready = 1'b1;
      got = 0; first_cyc = 0; last_cyc = 0;
      for (int unsigned c = 0; c < 30 && got < 4; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            chk($sformatf("bp_order%0d", got), out_result, bp_exp[got]);
            if (got == 0) first_cyc = cyc;
            last_cyc = cyc;
            got++;
         end
      end
      chk("bp_count", 64'(got), 4);
      chk("bp_one_per_cycle", 64'(last_cyc - first_cyc), 3);
      @(posedge clk); #1;
      wait fork;

      // Reset with E and W both occupied
      out_ready = 1'b0;
      send(7'b0110011, 3'b000, 1'b0, 64'd1, 64'd2, 64'd0, ok);
      send(7'b0110011, 3'b000, 1'b0, 64'd3, 64'd4, 64'd0, ok);
      chk("pre_rst_out_valid", 64'(out_valid), 1);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 0);
      chk("mid_rst_alu_op", 64'(alu_op), 0);
      chk("mid_rst_alu_a", alu_a, 0);
      chk("mid_rst_in_ready", 64'(in_ready), 1);
      chk("mid_rst_out_result", out_result, 0);
      out_ready = 1'b1;
      @(posedge clk); #2;
      reset = 1'b1;
      chk("post_rst_in_ready", 64'(in_ready), 1);
      send(7'b0110011, 3'b000, 1'b0, 64'd7, 64'd8, 64'd0, ok);
      chk("post_rst_e_stage", 64'(out_valid), 0);
      @(posedge clk); #1;
      chk("post_rst_out_valid", 64'(out_valid), 1);
      chk("post_rst_out_result", out_result, 64'd15);
      @(posedge clk); #1;

      // Randomized traffic with random downstream stalls
      for (int unsigned c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid || last_acc) begin
            logic [11:0] i12;
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 6))
               0:       opcode = 7'b0110011;
               1:       opcode = 7'b0010011;
               2:       opcode = 7'b0000011;
               3:       opcode = 7'b0100011;
               4, 5:    opcode = 7'b1100011;
               default: opcode = 7'($urandom);
            endcase
            if (opcode == 7'b1100011 && $urandom_range(0, 3) != 0)
               funct3 = $urandom_range(0, 1) ? 3'b100 : 3'b000;
            else
               funct3 = 3'($urandom);
            funct7_5 = 1'($urandom);
            if ($urandom_range(0, 1)) begin
               rs1_data = {$urandom, $urandom};
               rs2_data = {$urandom, $urandom};
            end else begin
               rs1_data = 64'($urandom_range(0, 20));
               rs2_data = 64'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 4) == 0) rs2_data = rs1_data;
            i12 = 12'($urandom);
            imm = {{52{i12[11]}}, i12};
         end
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int unsigned c = 0; c < 100; c++) begin
         @(posedge clk);
         if (exp_q.size() == 0 && !out_valid) break;
      end
      #1;
      chk("drain_queue_empty", 64'(exp_q.size()), 0);
      chk("drain_out_valid", 64'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
